// File: rtl/can_frame_tail_sequencer.sv
// CAN frame tail sequencer: CRC delimiter, ACK slot, ACK delimiter, EOF and
// intermission. Clocked by the bit sample point SP.
// Optional IFS overload detection is enabled by defining the
// CAN_TAIL_OVERLOAD_DETECT_EN macro. Without it, Overload_Req is tied low.
module can_frame_tail_sequencer #(
    parameter int unsigned EOF_BITS = 7,
    parameter int unsigned IFS_BITS = 3
) (
    input  logic SP,
    input  logic reset,
    input  logic RX,
    input  logic CRC_Done,
    output logic EOF_Flag,
    output logic Form_Error,
    output logic ACK_Missing,
    output logic Frame_Done,
    output logic Bus_Idle,
    output logic Overload_Req
);

    typedef enum logic [2:0] {
        StIdle,
        StCrcDel,
        StAckSlot,
        StAckDel,
        StEof,
        StIfs
    } state_e;

    localparam logic [3:0] EofLast = 4'(EOF_BITS - 1);
    localparam logic [3:0] IfsLast = 4'(IFS_BITS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       form_q, form_d;
    logic       ackm_q, ackm_d;
    logic       done_q, done_d;
    logic       eof_n_q, eof_n_d;
    logic       idle_q, idle_d;
    logic       ovl_d;

    // Next-state, bit counter and pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        form_d  = 1'b0;
        ackm_d  = 1'b0;
        done_d  = 1'b0;
        ovl_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CRC_Done) state_d = StCrcDel;
            end
            StCrcDel: begin
                if (!RX) begin
                    form_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StAckSlot;
                end
            end
            StAckSlot: begin
                // A recessive ACK slot is reported but never aborts the tail.
                ackm_d  = RX;
                state_d = StAckDel;
            end
            StAckDel: begin
                if (!RX) begin
                    form_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StEof;
                end
            end
            StEof: begin
                // RX is deliberately not checked; EOF errors are handled downstream.
                if (cnt_q == EofLast) begin
                    done_d  = 1'b1;
                    state_d = StIfs;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StIfs: begin
`ifdef CAN_TAIL_OVERLOAD_DETECT_EN
                // Dominant in the first two IFS bits is an overload request;
                // later it is taken as the next frame's SOF.
                if (!RX) begin
                    ovl_d   = (cnt_q < 4'd2);
                    state_d = StIdle;
                end else if (cnt_q == IfsLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`else
                if (cnt_q == IfsLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) cnt_d = '0;
        // Level outputs come from flops fed by the next state, so they are glitch-free.
        eof_n_d = (state_d != StEof);
        idle_d  = (state_d == StIdle);
    end

    // State, counter and output registers.
    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            form_q  <= 1'b0;
            ackm_q  <= 1'b0;
            done_q  <= 1'b0;
            eof_n_q <= 1'b1;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            form_q  <= form_d;
            ackm_q  <= ackm_d;
            done_q  <= done_d;
            eof_n_q <= eof_n_d;
            idle_q  <= idle_d;
        end
    end

`ifdef CAN_TAIL_OVERLOAD_DETECT_EN
    logic ovl_q;

    // Overload request pulse register.
    always_ff @(posedge SP or negedge reset) begin
        if (!reset) ovl_q <= 1'b0;
        else        ovl_q <= ovl_d;
    end

    assign Overload_Req = ovl_q;
`else
    assign Overload_Req = 1'b0;
`endif

    assign EOF_Flag    = eof_n_q;
    assign Form_Error  = form_q;
    assign ACK_Missing = ackm_q;
    assign Frame_Done  = done_q;
    assign Bus_Idle    = idle_q;

endmodule

// File: doc/can_frame_tail_sequencer.md
Name: can_frame_tail_sequencer

Overview:
- Sequences the fixed-form tail of a CAN frame once the decoder has sampled the last CRC bit: CRC delimiter, ACK slot, ACK delimiter, EOF field and intermission.
- Drives the active-low per-bit EOF_Flag consumed directly downstream by the EOF error checker.
- Reports form errors on the delimiters, a missing ACK, frame completion and bus idle.
- Clocked by the bit sample point SP; samples RX once per bit.

Parameters:
- EOF_BITS, 7, number of recessive EOF bits sequenced (legal 1..15).
- IFS_BITS, 3, number of intermission bits before the bus is declared idle (legal 1..15).

Ports:
- SP  input  1  sample-point clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- RX  input  1  destuffed bus bit, valid at SP rising edge (1 = recessive).
- CRC_Done  input  1  high at the SP edge that samples the last CRC bit.
- EOF_Flag  output  1  active-low; 0 during each bit period whose closing SP edge samples an EOF bit.
- Form_Error  output  1  one-SP-period pulse on a dominant CRC or ACK delimiter.
- ACK_Missing  output  1  one-SP-period pulse on a recessive ACK slot.
- Frame_Done  output  1  one-SP-period pulse after the last EOF bit is sampled.
- Bus_Idle  output  1  high while in IDLE.
- Overload_Req  output  1  one-SP-period pulse; functional only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (async, reset=0), all outputs held at these values:
  - state=IDLE, bit counter=0
  - EOF_Flag=1, Form_Error=0, ACK_Missing=0, Frame_Done=0, Overload_Req=0, Bus_Idle=1
- Reset mid-frame aborts immediately; no pulses are emitted.
- All outputs are registered (updated on the SP rising edge); there is no combinational path from RX to any output.
- Bit counter is 4 bits wide, cleared on every state entry.
- States, each transition evaluated at the SP rising edge:
  - IDLE: if CRC_Done=1, go to CRC_DEL; otherwise stay. CRC_Done is ignored in every other state.
  - CRC_DEL:
    - RX=0: Form_Error=1 for the following period, go to IDLE (abort, no Frame_Done).
    - RX=1: go to ACK_SLOT.
  - ACK_SLOT: RX=1 gives ACK_Missing=1 for the following period. Go to ACK_DEL unconditionally; no abort.
  - ACK_DEL:
    - RX=0: Form_Error=1, go to IDLE.
    - RX=1: go to EOF, with EOF_Flag=0 in the same edge.
  - EOF:
    - EOF_Flag=0 throughout. RX is not checked here; EOF errors belong to the downstream block.
    - Counter increments per edge. At the edge where counter=EOF_BITS-1: EOF_Flag=1, Frame_Done=1, go to IFS.
  - IFS:
    - Counter increments per edge. At the edge where counter=IFS_BITS-1, go to IDLE.
    - RX=0 during IFS: with the macro, see Optional Feature; without it, ignored.
- Bus_Idle=1 exactly when the registered state is IDLE. Bus_Idle falls on the edge leaving IDLE.
- EOF_Flag is low for exactly EOF_BITS consecutive SP periods per completed frame.
- Form_Error and Frame_Done are never high together.
- Pulses last exactly one SP period and clear at the next edge.

Optional Feature:
- Macro: CAN_TAIL_OVERLOAD_DETECT_EN.
- Defined:
  - RX=0 sampled in IFS with counter<2 (first or second intermission bit): Overload_Req=1 for one period, go to IDLE.
  - RX=0 in the third or later IFS bit: treated as SOF; go to IDLE with no pulse.
- Undefined:
  - Overload_Req is constant 0.
  - IFS counts IFS_BITS bits regardless of RX.

Test Plan:
- Reset, then CRC_Done pulse, RX=1 for all tail bits -> ACK_Missing pulses once; EOF_Flag low for exactly 7 SP periods starting 3 edges after CRC_Done; Frame_Done pulse once; Bus_Idle returns high 3 edges after Frame_Done.
- CRC_Done, RX=1 (CRC delimiter), RX=0 (ACK slot), RX=1... -> no ACK_Missing; normal 7-bit EOF_Flag window; Frame_Done=1.
- CRC_Done, then RX=0 at the CRC delimiter -> Form_Error=1 for one period; EOF_Flag stays 1; Frame_Done never asserted; Bus_Idle=1 next edge. Repeat with RX=0 at the ACK delimiter -> same result.
- reset driven 0 midway through EOF (counter=3) -> EOF_Flag=1 and Bus_Idle=1 immediately, without waiting for SP; after reset release, a fresh CRC_Done yields a full 7-bit EOF window.
- With the macro, RX=0 on the first intermission bit -> Overload_Req=1 one period; Bus_Idle=1. Without the macro -> Overload_Req=0; IDLE after 3 bits.
- CRC_Done held 1 continuously throughout a frame -> exactly one tail sequence; a new sequence starts only from IDLE.
